// File: rtl/dac_pkg.sv
// ---------------------------------------------------------------------------
// dac_pkg : shared waveform-mode and FSM-state types for the DAC wave path
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none
package dac_pkg;

  typedef enum logic [1:0] {
    MODE_DC     = 2'd0,
    MODE_RAMP   = 2'd1,
    MODE_TRI    = 2'd2,
    MODE_SQUARE = 2'd3
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_e;

  localparam int DAC_CODE_MAX = 4095;

endpackage
`default_nettype wire

// File: rtl/dac_wave_gen_if.sv
// ---------------------------------------------------------------------------
// dac_wave_gen_if : valid/ready sample link from generator to DAC serializer
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none
interface dac_wave_gen_if #(
  parameter int DATA_W = 12
) ();

  logic [DATA_W-1:0] sample_data;
  logic              sample_valid;
  logic              sample_ready;

  modport master (output sample_data, output sample_valid, input sample_ready);
  modport slave  (input sample_data, input sample_valid, output sample_ready);

endinterface
`default_nettype wire

// File: rtl/dac_rate_tick.sv
// ---------------------------------------------------------------------------
// dac_rate_tick : sample-rate divider, one tick every rate_div+1 enabled cycles
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none
module dac_rate_tick #(
  parameter int DIV_W = 16
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             enable,
  input  wire logic [DIV_W-1:0] rate_div,
  output logic                  tick
);

  logic [DIV_W-1:0] cnt_q;

  assign tick = enable && (cnt_q == rate_div);

  // The >= wrap keeps the counter bounded if rate_div shrinks below it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (!enable || (cnt_q >= rate_div)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dac_wave_gen.sv
// ---------------------------------------------------------------------------
// dac_wave_gen : DC/ramp/triangle/square sample generator for a serial DAC
// Triangle mode present only when DAC_WAVE_TRI_EN is defined. Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none
module dac_wave_gen
  import dac_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int DIV_W  = 16
) (
  input  wire logic              clk,
  input  wire logic              reset,
  input  wire logic              enable,
  input  wire logic [1:0]        mode,
  input  wire logic [DATA_W-1:0] step,
  input  wire logic [DATA_W-1:0] dc_level,
  input  wire logic [DIV_W-1:0]  rate_div,
  dac_wave_gen_if.master         smp,
  output logic [7:0]             underrun_cnt
);

  localparam logic [DATA_W-1:0] CODE_MAX = '1;

  state_e            state_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] phase_q;
  mode_e             last_mode_q;
  logic [7:0]        underrun_q;

  logic              tick;
  logic              xfer;
  logic              emit;
  mode_e             mode_eff;
  logic [DATA_W-1:0] phase_base;
  logic [DATA_W-1:0] phase_d;
  logic [DATA_W-1:0] data_d;

`ifdef DAC_WAVE_TRI_EN
  logic              dir_down_q;
  logic              dir_base;
  logic              dir_down_d;
  logic [DATA_W:0]   tri_sum;
`endif

  dac_rate_tick #(.DIV_W(DIV_W)) u_tick (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .rate_div (rate_div),
    .tick     (tick)
  );

  assign xfer = (state_q == ST_PEND) && smp.sample_ready;
  assign emit = tick && ((state_q == ST_IDLE) || xfer);

  always_comb begin
    mode_eff = mode_e'(mode);
`ifndef DAC_WAVE_TRI_EN
    if (mode_eff == MODE_TRI) mode_eff = MODE_RAMP;
`endif
    // A mode switch restarts the waveform from code 0 going up.
    phase_base = (mode != last_mode_q) ? '0 : phase_q;

    case (mode_eff)
      MODE_DC:     data_d = dc_level;
      MODE_SQUARE: data_d = {DATA_W{phase_base[DATA_W-1]}};
      default:     data_d = phase_base;
    endcase

    phase_d = phase_base + step;
`ifdef DAC_WAVE_TRI_EN
    dir_base   = (mode != last_mode_q) ? 1'b0 : dir_down_q;
    dir_down_d = dir_base;
    tri_sum    = {1'b0, phase_base} + {1'b0, step};
    if (mode_eff == MODE_TRI) begin
      if (!dir_base) begin
        if (tri_sum >= {1'b0, CODE_MAX}) begin
          phase_d    = CODE_MAX;
          dir_down_d = 1'b1;
        end else begin
          phase_d = tri_sum[DATA_W-1:0];
        end
      end else if (phase_base < step) begin
        phase_d    = '0;
        dir_down_d = 1'b0;
      end else begin
        phase_d = phase_base - step;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      data_q      <= '0;
      phase_q     <= '0;
      last_mode_q <= MODE_DC;
      underrun_q  <= '0;
`ifdef DAC_WAVE_TRI_EN
      dir_down_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: if (tick) state_q <= ST_PEND;
        ST_PEND: begin
          if (tick && !xfer) begin
            if (underrun_q != 8'hFF) underrun_q <= underrun_q + 8'd1;
          end else if (!tick && xfer) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
      if (emit) begin
        data_q      <= data_d;
        phase_q     <= phase_d;
        last_mode_q <= mode_e'(mode);
`ifdef DAC_WAVE_TRI_EN
        dir_down_q  <= dir_down_d;
`endif
      end
    end
  end

  assign smp.sample_data  = data_q;
  assign smp.sample_valid = (state_q == ST_PEND);
  assign underrun_cnt     = underrun_q;

endmodule
`default_nettype wire
